// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// a width helper for counters that must hold an inclusive maximum value.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Bits needed to represent every value in 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first valid requester searching upward,
// with wrap, starting just after the previous holder.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               any_valid,
    output logic [IDX_W-1:0]   sel_idx
);

    int              idx;
    logic [IDX_W-1:0] idx_bits;

    // Scan from the farthest candidate down to the nearest so the nearest valid one wins.
    always_comb begin
        any_valid = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        idx_bits  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx      = (int'(last_idx) + k) % NUM_REQ;
            idx_bits = IDX_W'(idx);
            if (req_valid[idx_bits]) begin
                any_valid = 1'b1;
                sel_idx   = idx_bits;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ packet sources;
// a grant is held per packet, capped by a burst limit and an idle timeout.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no holder; pick next valid requester after last_idx
//  ST_GRANT | grant_idx owns the port until last, burst limit or timeout
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic                          grant_active,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          timeout_event
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int BURST_W = cnt_width(MAX_BURST);
    localparam int IDLE_W  = cnt_width(IDLE_TIMEOUT);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               timeout_q, timeout_d;

    logic               any_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               g_valid;
    logic               g_last;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req_valid (req_valid),
        .last_idx  (last_idx_q),
        .any_valid (any_valid),
        .sel_idx   (sel_idx)
    );

    assign g_valid      = req_valid[grant_idx_q];
    assign g_last       = req_last[grant_idx_q];
    assign fifo_wr_data = req_data[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        timeout_d   = timeout_q;
        req_ready   = '0;
        fifo_wr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d     = ST_GRANT;
                    grant_idx_d = sel_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end

            ST_GRANT: begin
                req_ready[grant_idx_q] = !fifo_full;
                fifo_wr_en             = g_valid & !fifo_full;

                if (fifo_wr_en) begin
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    if (g_last || (burst_cnt_d == BURST_MAX)) begin
                        state_d    = ST_IDLE;
                        last_idx_d = grant_idx_q;
                    end
                end

                // A full-stalled but valid holder is not idle, so the counter only runs with valid low.
                if (g_valid) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if (idle_cnt_d == IDLE_MAX) begin
                        state_d    = ST_IDLE;
                        last_idx_d = grant_idx_q;
                        timeout_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= LAST_RST;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant_active  = (state_q == ST_GRANT);
    assign grant_idx     = grant_idx_q;
    assign timeout_event = timeout_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares one FIFO write port among `NUM_REQ` requesters, such as the AXI FIFO bridge write path and local stream sources. Each requester presents data on a valid/ready/last handshake. A grant is held for a packet (up to `MAX_BURST` words) and then rotates, so the FIFO receives whole packets without interleaving. An idle timeout releases a stalled grant so no requester can hang the port.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters, 2..16
- `DATA_WIDTH`, 32, word width
- `MAX_BURST`, 16, maximum words per grant, ≥1
- `IDLE_TIMEOUT`, 16, consecutive granted cycles with `req_valid` low before forced release, ≥1

Ports (reset is `aresetn`, synchronous, active-low; clock is `aclk`):
- `aclk`  in  1  clock
- `aresetn`  in  1  synchronous active-low reset
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_valid`  in  `NUM_REQ`  word valid, one bit per requester
- `req_last`  in  `NUM_REQ`  final word of packet, qualified by valid
- `req_ready`  out  `NUM_REQ`  word accepted this cycle when valid & ready
- `fifo_wr_data`  out  `DATA_WIDTH`  word to FIFO
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_full`  in  1  FIFO full
- `grant_active`  out  1  a requester currently holds the port
- `grant_idx`  out  `$clog2(NUM_REQ)`  index of the holder
- `timeout_event`  out  1  sticky; set on any timeout release

## Operation
- State machine has two states.
  - IDLE: no grant is held. If any `req_valid` is high, select the first requester with valid high, searching upward (with wrap) from `last_idx+1`. Register that index into `grant_idx` and move to GRANT.
  - GRANT: requester `g = grant_idx` owns the port.
- Datapath in GRANT, combinational:
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[g] & !fifo_full`.
  - `fifo_wr_data = req_data[g]`.
- In IDLE, all `req_ready` bits and `fifo_wr_en` are 0, and `fifo_wr_data` is don't-care.
- Burst counter (`$clog2(MAX_BURST+1)` bits) increments on each write and clears on entry to GRANT.
- Release to IDLE, with `last_idx <= g`, on the first of:
  - a write with `req_last[g]` set;
  - a write that makes burst count equal `MAX_BURST`;
  - the idle counter reaching `IDLE_TIMEOUT`. This also sets `timeout_event`.
- Idle counter:
  - increments on GRANT cycles where `req_valid[g]` is low;
  - clears on any cycle where `req_valid[g]` is high, including cycles stalled by `fifo_full`;
  - clears on entry to GRANT.
- `fifo_full` stalls do not count toward the timeout and do not release the grant.
- Reset values: state IDLE; `last_idx = NUM_REQ-1`, so requester 0 wins first; `grant_idx = 0`; `grant_active = 0`; counters 0; `timeout_event = 0`.
- Reset asserted mid-burst abandons the packet. No write occurs in the reset cycle's following state.

## Timing
- Arbitration latency: valid seen in IDLE → GRANT on the next cycle → first write in that GRANT cycle if `!fifo_full`.
- Minimum one-cycle IDLE bubble between successive grants.
- Throughput within a grant: one word per cycle while `req_valid[g]` is high and `fifo_full` is low.
- `grant_active` and `grant_idx` are registered, so they change only on the clock edge.
- `req_ready` and `fifo_wr_en` are combinational from state, `req_valid[g]` and `fifo_full`.
- Simultaneous events:
  - Last word and burst limit in the same cycle: a single release.
  - Timeout cannot coincide with a write, because the idle counter clears when valid is high.
- A requester dropping `req_valid` mid-packet keeps the grant until it sends `req_last`, hits the burst limit, or times out.

## Structure
- Shared package `fifo_arb_pkg`: state encoding constants (`ST_IDLE`, `ST_GRANT`) and a `clog2`-style width helper.
- Sub-module `rr_priority_select`: combinational round-robin picker.
  - Inputs: `req_valid` vector and `last_idx`.
  - Outputs: `any_valid` and `sel_idx`.
- Everything else lives in one module.

## Test plan
- Single requester: requester 1 sends a 3-word packet 0xA,0xB,0xC with `last` on 0xC. FIFO receives 0xA,0xB,0xC on 3 consecutive cycles starting the cycle after valid. Then IDLE, and `last_idx = 1`.
- Round-robin: all 4 requesters continuously send 1-word packets. Grant order is 0,1,2,3,0 with one IDLE cycle between grants.
- Burst limit: `MAX_BURST = 4`, requester 2 sends 10 words and never asserts `last`. Grant releases after 4 writes, re-grants to 2 only if no other requester is valid, and 3 grants are needed in total.
- `fifo_full` stall: `fifo_full` held high for 20 cycles mid-packet with valid high. No writes, no timeout, grant held; the packet completes after full drops.
- Timeout: `IDLE_TIMEOUT = 5`, requester 3 sends one word without `last`, then drops valid. Release occurs 5 cycles later, `timeout_event` becomes 1 and stays set until reset.
- Reset mid-burst: `aresetn` low for 1 cycle during a grant. The next cycle shows IDLE, `grant_active = 0`, no `fifo_wr_en`, and the following grant goes to requester 0 if it is valid.
